// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - core data-port MMIO bridge: RAM pass-through, GPIO bank, external cmd/rsp port
module mmio_bridge #(
    parameter int          GPIO_COUNT = 4,
    parameter int          GPIO_WIDTH = 16,
    parameter int          EXT_ADDR_W = 4,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_WORD   = 32'hDEAD_BEEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_sel,
    input  logic [31:0]                      req_addr,
    input  logic                             req_we,
    input  logic [31:0]                      req_wdata,
    input  logic [3:0]                       req_wmask,
    input  logic [31:0]                      mem_rdata,
    output logic                             rsp_valid,
    output logic [31:0]                      rsp_rdata,
    output logic                             cmd_valid,
    output logic                             cmd_write,
    output logic [EXT_ADDR_W-1:0]            cmd_addr,
    output logic [31:0]                      cmd_data,
    input  logic                             cmd_busy,
    input  logic                             rsp_stb,
    input  logic [31:0]                      rsp_word,
    output logic [GPIO_COUNT*GPIO_WIDTH-1:0] gpio_out,
    output logic                             err_sticky
);
    localparam int          IDX_W      = (GPIO_COUNT > 1) ? $clog2(GPIO_COUNT) : 1;
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, IO_RESP, EXT_ISSUE, EXT_WAIT, EXT_RESP} state_t;

    state_t                state;
    logic [GPIO_WIDTH-1:0] gpio_q [GPIO_COUNT];
    logic [GPIO_WIDTH-1:0] wr_merge;
    logic [31:0]           rd_ext;
    logic [31:0]           cap_q;
    logic [15:0]           tmo_cnt;
    logic [IDX_W-1:0]      idx;
    logic                  periph, gpio_hit, ext_hit, tmo_hit;
    logic                  unused_addr;

    assign periph      = req_sel & req_addr[31];
    assign gpio_hit    = periph & ~req_addr[30];
    assign ext_hit     = periph & req_addr[30];
    assign idx         = (GPIO_COUNT > 1) ? req_addr[2 +: IDX_W] : '0;
    assign tmo_hit     = (tmo_cnt == TIMEOUT_M1);
    assign unused_addr = ^req_addr;

    for (genvar g = 0; g < GPIO_COUNT; g++) begin : g_gpio_out
        assign gpio_out[g*GPIO_WIDTH +: GPIO_WIDTH] = gpio_q[g];
    end

    // Byte lanes beyond GPIO_WIDTH simply have no bits to write.
    always_comb begin
        wr_merge = gpio_q[idx];
        for (int b = 0; b < GPIO_WIDTH; b++) begin
            if (req_wmask[b >> 3]) wr_merge[b] = req_wdata[b];
        end
        rd_ext = '0;
        rd_ext[GPIO_WIDTH-1:0] = gpio_q[idx];
    end

    always_comb begin
        rsp_valid = 1'b0;
        rsp_rdata = 32'd0;
        case (state)
            IDLE: begin
                if (!periph) begin
                    rsp_valid = 1'b1;
                    rsp_rdata = mem_rdata;
                end
            end
            IO_RESP, EXT_RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = cap_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cap_q      <= 32'd0;
            tmo_cnt    <= 16'd0;
            cmd_valid  <= 1'b0;
            cmd_write  <= 1'b0;
            cmd_addr   <= '0;
            cmd_data   <= 32'd0;
            err_sticky <= 1'b0;
            for (int i = 0; i < GPIO_COUNT; i++) gpio_q[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gpio_hit) begin
                        if (req_we) begin
                            gpio_q[idx] <= wr_merge;
                            cap_q       <= 32'd0;
                        end else begin
                            cap_q <= rd_ext;
                        end
                        state <= IO_RESP;
                    end else if (ext_hit) begin
                        cmd_valid <= 1'b1;
                        cmd_write <= req_we;
                        cmd_addr  <= req_addr[EXT_ADDR_W-1:0];
                        cmd_data  <= req_wdata;
                        tmo_cnt   <= 16'd0;
                        state     <= EXT_ISSUE;
                    end
                end
                IO_RESP: state <= IDLE;
                EXT_ISSUE: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    // A response landing on the acceptance edge skips EXT_WAIT.
                    if (!cmd_busy && rsp_stb) begin
                        cap_q     <= rsp_word;
                        cmd_valid <= 1'b0;
                        state     <= EXT_RESP;
                    end else if (tmo_hit) begin
                        cap_q      <= ERR_WORD;
                        err_sticky <= 1'b1;
                        cmd_valid  <= 1'b0;
                        state      <= EXT_RESP;
                    end else if (!cmd_busy) begin
                        cmd_valid <= 1'b0;
                        state     <= EXT_WAIT;
                    end
                end
                EXT_WAIT: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (rsp_stb) begin
                        cap_q <= rsp_word;
                        state <= EXT_RESP;
                    end else if (tmo_hit) begin
                        cap_q      <= ERR_WORD;
                        err_sticky <= 1'b1;
                        state      <= EXT_RESP;
                    end
                end
                EXT_RESP: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - self-checking bench for mmio_bridge: vector table, directed corners, random vs model
module tb_mmio_bridge;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_sel, req_we;
    logic [31:0] req_addr, req_wdata, mem_rdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        cmd_valid, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_busy, rsp_stb;
    logic [31:0] rsp_word;
    logic [63:0] gpio_out;
    logic        err_sticky;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_gpio [4];
    logic        m_err;

    mmio_bridge #(
        .GPIO_COUNT(4), .GPIO_WIDTH(16), .EXT_ADDR_W(4),
        .TIMEOUT(TMO), .ERR_WORD(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst(rst),
        .req_sel(req_sel), .req_addr(req_addr), .req_we(req_we),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .cmd_busy(cmd_busy), .rsp_stb(rsp_stb), .rsp_word(rsp_word),
        .gpio_out(gpio_out), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_gpio(input string nm);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s gpio%0d", nm, i), 32'(gpio_out[i*16 +: 16]), 32'(m_gpio[i]));
        check({nm, " err_sticky"}, 32'(err_sticky), 32'(m_err));
    endtask

    // Presents one access in IDLE (cycle 0); ISSUE/WAIT cycles are numbered from 1.
    task automatic run_access(input string nm, input logic sel, input logic [31:0] addr,
                              input logic we, input logic [31:0] wdata, input logic [3:0] wmask,
                              input logic [31:0] mrd, input int busy_n, input int stb_at,
                              input logic [31:0] word, input int exp_lat, input int exp_cmd_n,
                              input logic [31:0] exp_rdata);
        for (int c = 0; c <= exp_lat; c++) begin
            @(negedge clk);
            req_sel   = sel;
            req_addr  = addr;
            req_we    = we;
            req_wdata = wdata;
            req_wmask = wmask;
            mem_rdata = mrd;
            cmd_busy  = (c >= 1 && c <= busy_n);
            rsp_stb   = (c >= 1 && c == stb_at);
            rsp_word  = (c == stb_at) ? word : $urandom;
            #1;
            check($sformatf("%s c%0d rsp_valid", nm, c), 32'(rsp_valid), 32'(c == exp_lat));
            if (c == exp_lat) check($sformatf("%s rsp_rdata", nm), rsp_rdata, exp_rdata);
            check($sformatf("%s c%0d cmd_valid", nm, c), 32'(cmd_valid),
                  32'(c >= 1 && c <= exp_cmd_n));
            if (c >= 1 && c <= exp_cmd_n) begin
                check($sformatf("%s c%0d cmd_addr", nm, c), 32'(cmd_addr), 32'(addr[3:0]));
                check($sformatf("%s c%0d cmd_write", nm, c), 32'(cmd_write), 32'(we));
                check($sformatf("%s c%0d cmd_data", nm, c), cmd_data, wdata);
            end
        end
    endtask

    // Response timing derived from acceptance cycle, strobe cycle and the timeout budget.
    function automatic void ext_model(input int busy_n, input int stb_at,
                                      output int lat, output int cmd_n, output logic tmo);
        int acc;
        acc = busy_n + 1;
        if (stb_at >= acc && stb_at <= TMO) begin
            lat = stb_at + 1; cmd_n = acc; tmo = 1'b0;
        end else begin
            lat = TMO + 1; cmd_n = (acc < TMO) ? acc : TMO; tmo = 1'b1;
        end
    endfunction

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] mrd;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0010, 1'b0, 32'h0, 4'h0, 32'h1234_5678, 0, 32'h1234_5678};
        vecs[1] = '{1'b0, 32'hC000_0000, 1'b1, 32'h0, 4'hF, 32'hCAFE_0001, 0, 32'hCAFE_0001};
        vecs[2] = '{1'b1, 32'h8000_0004, 1'b1, 32'hAAAA_BBBB, 4'b0001, 32'h0, 1, 32'h0};
        vecs[3] = '{1'b1, 32'h8000_0004, 1'b1, 32'h0000_CC00, 4'b0010, 32'h0, 1, 32'h0};
        vecs[4] = '{1'b1, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 32'h0, 1, 32'h0000_CCBB};
        vecs[5] = '{1'b1, 32'h8000_000C, 1'b1, 32'h1234_5678, 4'b1111, 32'h0, 1, 32'h0};
        vecs[6] = '{1'b1, 32'h8000_000C, 1'b0, 32'h0, 4'h0, 32'h0, 1, 32'h0000_5678};
        vecs[7] = '{1'b1, 32'h4000_0000, 1'b0, 32'h0, 4'h0, 32'h7777_0000, 0, 32'h7777_0000};

        rst = 1'b1; req_sel = 1'b0; req_addr = 32'h0; req_we = 1'b0; req_wdata = 32'h0;
        req_wmask = 4'h0; mem_rdata = 32'h0; cmd_busy = 1'b0; rsp_stb = 1'b0; rsp_word = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        m_gpio = '{16'h0, 16'h0, 16'h0, 16'h0};
        m_err  = 1'b0;
        check_gpio("reset");
        check("reset cmd_valid", 32'(cmd_valid), 32'h0);
        check("reset cmd_write", 32'(cmd_write), 32'h0);
        check("reset cmd_addr", 32'(cmd_addr), 32'h0);
        check("reset cmd_data", cmd_data, 32'h0);

        foreach (vecs[i])
            run_access($sformatf("vec%0d", i), vecs[i].sel, vecs[i].addr, vecs[i].we,
                       vecs[i].wdata, vecs[i].wmask, vecs[i].mrd, 0, 0, 32'h0,
                       vecs[i].lat, 0, vecs[i].rdata);
        m_gpio = '{16'h0, 16'hCCBB, 16'h0, 16'h5678};
        check_gpio("table");

        // busy for 3 cycles, accepted in cycle 4, strobe two WAIT cycles later
        run_access("ext_busy", 1'b1, 32'hC000_0003, 1'b0, 32'h0, 4'h0, 32'h0,
                   3, 6, 32'h0BAD_F00D, 7, 4, 32'h0BAD_F00D);
        run_access("stb_on_accept", 1'b1, 32'hC000_0009, 1'b1, 32'h5A5A_1234, 4'hF, 32'h0,
                   2, 3, 32'h600D_0001, 4, 3, 32'h600D_0001);
        run_access("stb_on_timeout", 1'b1, 32'hC000_000E, 1'b0, 32'h0, 4'h0, 32'h0,
                   0, TMO, 32'h600D_0002, TMO + 1, 1, 32'h600D_0002);
        check_gpio("after_good_ext");
        run_access("timeout", 1'b1, 32'hC000_0005, 1'b1, 32'h1357_9BDF, 4'hF, 32'h0,
                   0, 0, 32'h0, TMO + 1, 1, 32'hDEAD_BEEF);
        m_err = 1'b1;
        check_gpio("after_timeout");
        run_access("ram_after_err", 1'b1, 32'h0000_0100, 1'b0, 32'h0, 4'h0, 32'h2468_ACE0,
                   0, 0, 32'h0, 0, 0, 32'h2468_ACE0);
        check_gpio("err_persists");

        // reset while waiting for the external response
        @(negedge clk);
        req_sel = 1'b1; req_addr = 32'hC000_0002; req_we = 1'b0; cmd_busy = 1'b0; rsp_stb = 1'b0;
        @(negedge clk);
        #1 check("rst_seq issue cmd_valid", 32'(cmd_valid), 32'h1);
        @(negedge clk);
        #1 check("rst_seq wait rsp_valid", 32'(rsp_valid), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_sel = 1'b0; mem_rdata = 32'h5555_AAAA; rsp_stb = 1'b1;
        rsp_word = 32'h1111_2222;
        #1;
        m_gpio = '{16'h0, 16'h0, 16'h0, 16'h0};
        m_err  = 1'b0;
        check("rst_seq cmd_valid", 32'(cmd_valid), 32'h0);
        check("rst_seq rsp_valid", 32'(rsp_valid), 32'h1);
        check("rst_seq rsp_rdata", rsp_rdata, 32'h5555_AAAA);
        check_gpio("rst_seq");
        @(negedge clk);
        rsp_stb = 1'b0; req_sel = 1'b1; req_addr = 32'h0000_0040; mem_rdata = 32'h9999_0000;
        #1;
        check("rst_seq late_stb rsp_valid", 32'(rsp_valid), 32'h1);
        check("rst_seq late_stb rsp_rdata", rsp_rdata, 32'h9999_0000);

        for (int n = 0; n < 80; n++) begin
            int          kind, busy_n, stb_at, lat, cmd_n, gi;
            logic        tmo, we, sel;
            logic [31:0] a, wd, mr, wo, exp;
            logic [3:0]  wm;
            kind = $urandom_range(0, 2);
            a = $urandom; wd = $urandom; mr = $urandom; wo = $urandom;
            wm = 4'($urandom); we = 1'($urandom);
            if (kind == 0) begin
                sel = 1'($urandom);
                if (sel) a[31] = 1'b0;
                run_access($sformatf("rnd%0d ram", n), sel, a, we, wd, wm, mr,
                           0, 0, 32'h0, 0, 0, mr);
            end else if (kind == 1) begin
                gi = $urandom_range(0, 3);
                a[31:30] = 2'b10;
                a[3:2]   = 2'(gi);
                exp = we ? 32'h0 : {16'h0, m_gpio[gi]};
                run_access($sformatf("rnd%0d gpio", n), 1'b1, a, we, wd, wm, mr,
                           0, 0, 32'h0, 1, 0, exp);
                if (we) begin
                    if (wm[0]) m_gpio[gi][7:0]  = wd[7:0];
                    if (wm[1]) m_gpio[gi][15:8] = wd[15:8];
                end
            end else begin
                a[31:30] = 2'b11;
                busy_n = $urandom_range(0, 9);
                stb_at = ($urandom_range(0, 1) == 0) ? 0 : busy_n + 1 + $urandom_range(0, 6);
                ext_model(busy_n, stb_at, lat, cmd_n, tmo);
                exp = tmo ? 32'hDEAD_BEEF : wo;
                run_access($sformatf("rnd%0d ext", n), 1'b1, a, we, wd, wm, mr,
                           busy_n, stb_at, wo, lat, cmd_n, exp);
                if (tmo) m_err = 1'b1;
            end
            #1 check_gpio($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
Parametrised memory-mapped I/O bridge between the pipelined core's data port and everything outside RAM. It decodes the top two address bits into RAM, a local GPIO register bank and an external command/response port. It returns a per-access valid/stall signal to the core. Over a fixed-function IO wrapper it adds N byte-masked GPIO registers with readback, a handshaked external-port FSM and a response timeout with error reporting.

Parameters:
GPIO_COUNT, 4, number of GPIO output registers (power of two, 1..16)
GPIO_WIDTH, 16, width of each GPIO register (1..32)
EXT_ADDR_W, 4, external command address width (taken from req_addr LSBs)
TIMEOUT, 255, max cycles from entering EXT_ISSUE to rsp_stb before abort (1..65535)
ERR_WORD, 32'hDEAD_BEEF, read data returned on timeout

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_sel  in  1  core data access targets peripheral space (core peripherals_selected)
req_addr  in  32  core data address
req_we  in  1  write strobe
req_wdata  in  32  write data
req_wmask  in  4  byte mask
mem_rdata  in  32  RAM read data
rsp_valid  out  1  access complete; core stalls while 0
rsp_rdata  out  32  read data to core
cmd_valid  out  1  external command valid
cmd_write  out  1  external command is write
cmd_addr  out  EXT_ADDR_W  external command address
cmd_data  out  32  external write data
cmd_busy  in  1  external side cannot accept
rsp_stb  in  1  external response strobe (1 cycle)
rsp_word  in  32  external response data
gpio_out  out  GPIO_COUNT*GPIO_WIDTH  GPIO registers, reg i at [i*GPIO_WIDTH +: GPIO_WIDTH]
err_sticky  out  1  set on any timeout, cleared only by rst

Behaviour:
- Region = req_addr[31:30]: 00/01 RAM, 10 GPIO, 11 EXT. Region is ignored when req_sel=0; such accesses are treated as RAM.
- RAM (or req_sel=0): combinational rsp_valid=1, rsp_rdata=mem_rdata. No state change.
- FSM states: IDLE, IO_RESP, EXT_ISSUE, EXT_WAIT, EXT_RESP. Reset → IDLE.
- IDLE + GPIO access: on the edge, a write updates register idx=req_addr[2 +: log2(GPIO_COUNT)]. Byte k (bits 8k+7:8k, clipped to GPIO_WIDTH) is written iff req_wmask[k]. A read latches the zero-extended register. Next state IO_RESP.
- IO_RESP: rsp_valid=1, rsp_rdata=latched value (write returns 0); → IDLE. Total latency 1 cycle. The core advances on rsp_valid, so a held request is never applied twice.
- IDLE + EXT access: latch write flag, addr[EXT_ADDR_W-1:0] and wdata; → EXT_ISSUE.
- EXT_ISSUE: cmd_valid=1 with latched fields. On the first edge with cmd_busy=0 → EXT_WAIT. If rsp_stb=1 on that same edge, go straight to EXT_RESP with rsp_word captured.
- EXT_WAIT: cmd_valid=0. rsp_stb=1 → capture rsp_word, → EXT_RESP. rsp_stb while not in ISSUE/WAIT is ignored.
- Timeout counter: cleared on entry to EXT_ISSUE, increments each cycle in ISSUE/WAIT. If it reaches TIMEOUT with no rsp_stb → capture ERR_WORD, set err_sticky, → EXT_RESP. cmd_valid drops. rsp_stb on the timeout cycle wins over the timeout.
- EXT_RESP: rsp_valid=1, rsp_rdata=captured word; → IDLE.
- rsp_valid=0 in IDLE for GPIO/EXT accesses and in EXT_ISSUE/EXT_WAIT.
- Reset values: FSM IDLE, all gpio_out 0, cmd_valid 0, cmd_write 0, cmd_addr 0, cmd_data 0, err_sticky 0, captured data 0. rsp_valid follows decode: 1 for RAM/unselected, else 0.
- rst mid-transaction aborts immediately to IDLE; cmd_valid low the next cycle; no late rsp_stb is reported.
- cmd_* outputs are registered. rsp_valid/rsp_rdata are combinational from state and decode.

Test Plan:
- After rst, RAM read with mem_rdata=32'h1234_5678 → rsp_valid=1 the same cycle, rsp_rdata=32'h1234_5678; gpio_out=0.
- GPIO write addr 32'h8000_0004, wdata 32'hAAAA_BBBB, wmask 4'b0001 → reg1=16'h00BB. Then wmask 4'b0010 with wdata 32'h0000_CC00 → reg1=16'hCCBB. Readback → rsp_rdata=32'h0000_CCBB, rsp_valid exactly one cycle after request.
- EXT read addr 32'hC000_0003 with cmd_busy=1 for 3 cycles → cmd_valid held 4 cycles with cmd_addr=3. rsp_stb with rsp_word=32'h0BAD_F00D two cycles later → rsp_valid=1 one cycle later, rdata=32'h0BAD_F00D.
- EXT write with TIMEOUT=8 and rsp_stb never asserted → rsp_valid after timeout with rdata=32'hDEAD_BEEF, err_sticky=1 and stays 1 through a subsequent good access.
- rsp_stb asserted on the same edge the command is accepted, and rsp_stb on the timeout cycle → data taken, err_sticky unchanged.
- rst asserted in EXT_WAIT → next cycle IDLE, cmd_valid=0, err_sticky=0. A following rsp_stb is ignored; the next RAM access completes immediately.
